// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcode map, sequencer
// states, IR field positions, the strobe bundle and opcode class helpers.
package cpu_ctrl_pkg;

  localparam int OP_W = 5;
  localparam int RF_W = 4;

  // Opcode map
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // IR field bit positions
  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  // Single-bit strobes driven toward the datapath
  typedef struct packed {
    logic pc_out;
    logic pc_increment;
    logic pc_in;
    logic mar_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
    logic halted;
    logic illegal;
  } ctrl_t;

  // Register-register ALU instructions (take the T4/T5 path)
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV: is_alu_op = 1'b1;
      default:                                 is_alu_op = 1'b0;
    endcase
  endfunction

  // ALU ops whose result lands in HI/LO instead of a general register
  function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
    is_hilo_op = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Turns a register-number field into a one-hot enable vector, all-zero when
// not enabled. Field values beyond NREGS decode to nothing.
module reg_field_decoder #(
  parameter int NREGS = 16,
  parameter int FW    = 4
) (
  input  logic [FW-1:0]    i_field,
  input  logic             i_en,
  output logic [NREGS-1:0] o_onehot
);

  // One comparator per register bit
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      o_onehot[i] = i_en && (i_field == FW'(i));
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: sequences fetch (T0..T2) and register-register ALU
// execute (T3..T6), producing Moore strobes from the state and the IR.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  output logic             pc_out,
  output logic             pc_increment,
  output logic             pc_in,
  output logic             MARin,
  output logic             read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             zlow_in,
  output logic             zhigh_in,
  output logic             zlow_out,
  output logic             zhigh_out,
  output logic             hi_in,
  output logic             lo_in,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic [OPW-1:0]   op_code,
  output logic             halted,
  output logic             illegal
);

  state_e          r_state;
  state_e          w_next;
  state_e          w_end_next;
  ctrl_t           w_ctl;
  logic [OP_W-1:0] w_opc;
  logic [RF_W-1:0] w_ra;
  logic [RF_W-1:0] w_rb;
  logic [RF_W-1:0] w_rc;
  logic [RF_W-1:0] w_rout_field;
  logic            w_is_alu;
  logic            w_is_hilo;
  logic            w_rin_en;
  logic            w_rout_en;
  logic [OP_W-1:0] w_alu_op;
  logic            w_unused_ir;

  assign w_opc     = ir[IR_OP_HI:IR_OP_LO];
  assign w_ra      = ir[IR_RA_HI:IR_RA_LO];
  assign w_rb      = ir[IR_RB_HI:IR_RB_LO];
  assign w_rc      = ir[IR_RC_HI:IR_RC_LO];
  assign w_is_alu  = is_alu_op(w_opc);
  assign w_is_hilo = is_hilo_op(w_opc);
  assign w_unused_ir = ^ir[IR_RC_LO-1:0];

  // End of an instruction: loop straight into the next fetch while run holds
  assign w_end_next = run ? S_T0 : S_IDLE;

  // State register; clr aborts anything in flight immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = run ? S_T0 : S_IDLE;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3: begin
        if (w_is_alu)              w_next = S_T4;
        else if (w_opc == OP_HALT) w_next = S_HALT;
        else                       w_next = w_end_next;
      end
      S_T4:   w_next = S_T5;
      S_T5:   w_next = w_is_hilo ? S_T6 : w_end_next;
      S_T6:   w_next = w_end_next;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state single-bit strobes (Moore: state plus held IR only)
  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_T0: begin
        w_ctl.pc_out       = 1'b1;
        w_ctl.mar_in       = 1'b1;
        w_ctl.pc_increment = 1'b1;
        w_ctl.zlow_in      = 1'b1;
        w_ctl.zhigh_in     = 1'b1;
      end
      S_T1: begin
        w_ctl.zlow_out = 1'b1;
        w_ctl.pc_in    = 1'b1;
        w_ctl.read     = 1'b1;
        w_ctl.mdr_in   = 1'b1;
      end
      S_T2: begin
        w_ctl.mdr_out = 1'b1;
        w_ctl.ir_in   = 1'b1;
      end
      S_T3: begin
        w_ctl.y_in    = w_is_alu;
        w_ctl.illegal = !w_is_alu && (w_opc != OP_HALT) && (w_opc != OP_NOP);
      end
      S_T4: begin
        w_ctl.zlow_in  = 1'b1;
        w_ctl.zhigh_in = 1'b1;
      end
      S_T5: begin
        w_ctl.zlow_out = 1'b1;
        w_ctl.lo_in    = w_is_hilo;
      end
      S_T6: begin
        w_ctl.zhigh_out = 1'b1;
        w_ctl.hi_in     = 1'b1;
      end
      S_HALT:  w_ctl.halted = 1'b1;
      default: w_ctl = '0;
    endcase
  end

  // Register-file enables: Rb drives in T3, Rc in T4, Ra is written in T5
  always_comb begin
    w_rout_en    = ((r_state == S_T3) && w_is_alu) || (r_state == S_T4);
    w_rout_field = (r_state == S_T4) ? w_rc : w_rb;
    w_rin_en     = (r_state == S_T5) && !w_is_hilo;
    w_alu_op     = (r_state == S_T4) ? w_opc : '0;
  end

  reg_field_decoder #(.NREGS(NREGS), .FW(RF_W)) u_dec_out (
    .i_field  (w_rout_field),
    .i_en     (w_rout_en),
    .o_onehot (reg_out)
  );

  reg_field_decoder #(.NREGS(NREGS), .FW(RF_W)) u_dec_in (
    .i_field  (w_ra),
    .i_en     (w_rin_en),
    .o_onehot (reg_in)
  );

  assign pc_out       = w_ctl.pc_out;
  assign pc_increment = w_ctl.pc_increment;
  assign pc_in        = w_ctl.pc_in;
  assign MARin        = w_ctl.mar_in;
  assign read         = w_ctl.read;
  assign mdr_in       = w_ctl.mdr_in;
  assign mdr_out      = w_ctl.mdr_out;
  assign ir_in        = w_ctl.ir_in;
  assign y_in         = w_ctl.y_in;
  assign zlow_in      = w_ctl.zlow_in;
  assign zhigh_in     = w_ctl.zhigh_in;
  assign zlow_out     = w_ctl.zlow_out;
  assign zhigh_out    = w_ctl.zhigh_out;
  assign hi_in        = w_ctl.hi_in;
  assign lo_in        = w_ctl.lo_in;
  assign halted       = w_ctl.halted;
  assign illegal      = w_ctl.illegal;
  assign op_code      = OPW'(w_alu_op);

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed vector table, a per-instruction
// reference model for randomized streams, and hand-written corner sequences.
module tb_alu_control_sequencer;

  localparam int NREGS = 16;
  localparam int OPW   = 5;

  // Bit positions of the single-bit strobes in the comparison vector
  localparam int B_PCO = 0, B_PCINC = 1, B_PCIN = 2, B_MAR = 3, B_RD = 4;
  localparam int B_MDRIN = 5, B_MDROUT = 6, B_IRIN = 7, B_YIN = 8, B_ZLI = 9;
  localparam int B_ZHI = 10, B_ZLO = 11, B_ZHO = 12, B_HIIN = 13, B_LOIN = 14;
  localparam int B_HALT = 15, B_ILL = 16;

  localparam logic [16:0] C_T0   = 17'((1<<B_PCO)|(1<<B_MAR)|(1<<B_PCINC)|(1<<B_ZLI)|(1<<B_ZHI));
  localparam logic [16:0] C_T1   = 17'((1<<B_ZLO)|(1<<B_PCIN)|(1<<B_RD)|(1<<B_MDRIN));
  localparam logic [16:0] C_T2   = 17'((1<<B_MDROUT)|(1<<B_IRIN));
  localparam logic [16:0] C_YIN  = 17'(1<<B_YIN);
  localparam logic [16:0] C_Z    = 17'((1<<B_ZLI)|(1<<B_ZHI));
  localparam logic [16:0] C_ZLO  = 17'(1<<B_ZLO);
  localparam logic [16:0] C_LO   = 17'((1<<B_ZLO)|(1<<B_LOIN));
  localparam logic [16:0] C_HI   = 17'((1<<B_ZHO)|(1<<B_HIIN));
  localparam logic [16:0] C_HALT = 17'(1<<B_HALT);
  localparam logic [16:0] C_ILL  = 17'(1<<B_ILL);

  typedef struct packed {
    logic [16:0] ctl;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
  } row_t;

  typedef struct {
    logic [31:0] ir;
    row_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic clr, run;
  logic [31:0] ir;
  logic pc_out, pc_increment, pc_in, MARin, read, mdr_in, mdr_out, ir_in, y_in;
  logic zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in, halted, illegal;
  logic [NREGS-1:0] reg_in, reg_out;
  logic [OPW-1:0] op_code;
  logic [16:0] act_ctl;

  int checks = 0;
  int errors = 0;
  row_t expq[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  alu_control_sequencer #(.NREGS(NREGS), .OPW(OPW)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir),
    .pc_out(pc_out), .pc_increment(pc_increment), .pc_in(pc_in), .MARin(MARin),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .zlow_in(zlow_in), .zhigh_in(zhigh_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .hi_in(hi_in), .lo_in(lo_in), .reg_in(reg_in), .reg_out(reg_out),
    .op_code(op_code), .halted(halted), .illegal(illegal)
  );

  assign act_ctl = {illegal, halted, lo_in, hi_in, zhigh_out, zlow_out, zhigh_in,
                    zlow_in, y_in, ir_in, mdr_out, mdr_in, read, MARin, pc_in,
                    pc_increment, pc_out};

  function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction

  function automatic row_t mkrow(input logic [16:0] c, input logic [15:0] ri,
                                 input logic [15:0] ro, input logic [4:0] o);
    row_t r;
    r.ctl = c; r.rin = ri; r.rout = ro; r.op = o;
    return r;
  endfunction

  // Reference: list of per-cycle outputs for one whole instruction
  function automatic void build(input logic [31:0] irv);
    logic [4:0] opc;
    logic [15:0] ra1, rb1, rc1;
    opc = irv[31:27];
    ra1 = 16'h1 << irv[26:23];
    rb1 = 16'h1 << irv[22:19];
    rc1 = 16'h1 << irv[18:15];
    expq.delete();
    expq.push_back(mkrow(C_T0, '0, '0, '0));
    expq.push_back(mkrow(C_T1, '0, '0, '0));
    expq.push_back(mkrow(C_T2, '0, '0, '0));
    if (opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                    5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000}) begin
      expq.push_back(mkrow(C_YIN, '0, rb1, '0));
      expq.push_back(mkrow(C_Z, '0, rc1, opc));
      if (opc == 5'b01111 || opc == 5'b10000) begin
        expq.push_back(mkrow(C_LO, '0, '0, '0));
        expq.push_back(mkrow(C_HI, '0, '0, '0));
      end else begin
        expq.push_back(mkrow(C_ZLO, ra1, '0, '0));
      end
    end else if (opc == 5'b11010 || opc == 5'b11011) begin
      expq.push_back(mkrow('0, '0, '0, '0));
    end else begin
      expq.push_back(mkrow(C_ILL, '0, '0, '0));
    end
  endfunction

  task automatic chk(input string nm, input row_t e);
    row_t a;
    a = mkrow(act_ctl, reg_in, reg_out, op_code);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got ctl=%h rin=%h rout=%h op=%h want ctl=%h rin=%h rout=%h op=%h",
               nm, a.ctl, a.rin, a.rout, a.op, e.ctl, e.rin, e.rout, e.op);
    end
  endtask

  // Run one instruction from T0; optionally drop run at cycle drop_at and
  // then expect 'gap' idle cycles before run returns. ncyc<0 runs it all.
  task automatic run_instr(input string nm, input logic [31:0] irv, input int drop_at,
                           input int gap, input int ncyc);
    int n;
    build(irv);
    n = (ncyc < 0) ? expq.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) ir = irv;
      if (gap > 0 && i == drop_at) run = 1'b0;
      #1;
      chk($sformatf("%s_c%0d", nm, i), expq[i]);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s_idle%0d", nm, g), '0);
      if (g == gap - 1) run = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir_shl, ir_mul, irv;
    logic [4:0] opc;
    logic [4:0] alu_ops[11];
    int gap;

    alu_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000};
    ir_shl = 32'h5A3B8000;
    ir_mul = mkir(5'b01111, 4'd2, 4'd3, 4'd5);

    tbl[0]  = '{ir_shl, mkrow(C_T0, '0, '0, '0)};
    tbl[1]  = '{ir_shl, mkrow(C_T1, '0, '0, '0)};
    tbl[2]  = '{ir_shl, mkrow(C_T2, '0, '0, '0)};
    tbl[3]  = '{ir_shl, mkrow(C_YIN, '0, 16'h0080, '0)};
    tbl[4]  = '{ir_shl, mkrow(C_Z, '0, 16'h0080, 5'b01011)};
    tbl[5]  = '{ir_shl, mkrow(C_ZLO, 16'h0010, '0, '0)};
    tbl[6]  = '{ir_mul, mkrow(C_T0, '0, '0, '0)};
    tbl[7]  = '{ir_mul, mkrow(C_T1, '0, '0, '0)};
    tbl[8]  = '{ir_mul, mkrow(C_T2, '0, '0, '0)};
    tbl[9]  = '{ir_mul, mkrow(C_YIN, '0, 16'h0008, '0)};
    tbl[10] = '{ir_mul, mkrow(C_Z, '0, 16'h0020, 5'b01111)};
    tbl[11] = '{ir_mul, mkrow(C_LO, '0, '0, '0)};
    tbl[12] = '{ir_mul, mkrow(C_HI, '0, '0, '0)};

    // Reset held with run high: everything quiet
    clr = 1'b1; run = 1'b1; ir = '0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset", '0);
    end
    clr = 1'b0;

    // Directed table: shl then mul back to back
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ir = tbl[i].ir;
      #1;
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Randomized stream, occasionally dropping run mid-instruction
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1: opc = alu_ops[$urandom_range(0, 10)];
        2:    opc = 5'b11010;
        default: begin
          opc = 5'($urandom_range(0, 31));
          if (opc == 5'b11011) opc = 5'b11010;
        end
      endcase
      irv = mkir(opc, 4'($urandom), 4'($urandom), 4'($urandom));
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_instr($sformatf("rnd%0d", k), irv, 1, gap, -1);
    end

    // Equal register fields, R0 as destination
    run_instr("same_regs", mkir(5'b00011, 4'd0, 4'd0, 4'd0), 0, 0, -1);
    // div goes through HI/LO
    run_instr("div", mkir(5'b10000, 4'd9, 4'd1, 4'd15), 0, 0, -1);
    // run dropped in T4 of an add: finish, idle two cycles, restart
    run_instr("add_drop", mkir(5'b00011, 4'd1, 4'd2, 4'd3), 4, 2, -1);
    // Undefined opcode pulses illegal once, then fetch continues
    run_instr("illegal", mkir(5'b11111, 4'd1, 4'd1, 4'd1), 0, 0, -1);
    run_instr("after_ill", mkir(5'b00100, 4'd6, 4'd5, 4'd4), 0, 0, -1);

    // Async clear between edges during T4
    run_instr("clr_mid", mkir(5'b00011, 4'd3, 4'd4, 4'd5), 0, 0, 5);
    #1 clr = 1'b1;
    #1 chk("clr_async", '0);
    #1 clr = 1'b0;
    run_instr("restart", mkir(5'b00110, 4'd8, 4'd10, 4'd12), 0, 0, -1);

    // Halt parks with only halted set
    run_instr("halt", mkir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 0, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk($sformatf("halted%0d", i), mkrow(C_HALT, '0, '0, '0));
    end
    @(negedge clk);
    clr = 1'b1;
    #1 chk("halt_clr", '0);
    @(negedge clk);
    clr = 1'b0;
    run_instr("post_halt", mkir(5'b01001, 4'd11, 4'd13, 4'd14), 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired control unit that produces the per-cycle control strobes the Datapath consumes for fetch and register-register ALU instructions.
- It is the driving end of the Datapath control interface. Each cycle it generates the same strobe set that benches otherwise toggle by hand.
- It reads the IR contents back from the Datapath and sequences T0..T6 for each instruction.
- It loops fetch/execute while run is high and parks in HALT on a halt opcode.

Parameters:
- NREGS, 16, number of general registers; width of the one-hot reg_in/reg_out buses.
- OPW, 5, opcode and alu_op width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- run  in  1  level; enables leaving IDLE and continuing to the next fetch.
- ir  in  32  Datapath IR contents. IR[31:27] opcode, IR[26:23] Ra (dest), IR[22:19] Rb, IR[18:15] Rc.
- pc_out, pc_increment, pc_in  out  1  PC strobes.
- MARin  out  1  MAR load.
- read, mdr_in, mdr_out  out  1  memory read and MDR strobes.
- ir_in  out  1  IR load.
- y_in  out  1  Y load.
- zlow_in, zhigh_in, zlow_out, zhigh_out  out  1  Z register strobes.
- hi_in, lo_in  out  1  HI/LO load.
- reg_in  out  NREGS  one-hot general-register load enables.
- reg_out  out  NREGS  one-hot general-register bus drive enables.
- op_code  out  OPW  ALU operation; 5'b00000 whenever zlow_in is low.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.

Behaviour:
- Reset: clr high → state IDLE immediately, independent of clk. Every output is 0 while clr is high and in IDLE. Reset mid-instruction aborts with no further strobes.
- Outputs are Moore: decoded from the state register and the current ir only.
- At most one reg_out bit and one bus-driving strobe (pc_out, mdr_out, zlow_out, zhigh_out, reg_out) are active in any cycle.
- IDLE: run=1 → T0, else stay.
- T0: pc_out, MARin, pc_increment, zlow_in, zhigh_in. Next T1.
- T1: zlow_out, pc_in, read, mdr_in. Next T2.
- T2: mdr_out, ir_in. IR latches at the end of T2. Next T3.
- T3: decode ir[31:27].
  - ALU class: reg_out[Rb], y_in; next T4.
  - halt: no strobes; next HALT.
  - nop: no strobes; next END.
  - undefined: illegal=1, no strobes; next END.
- T4: reg_out[Rc], zlow_in, zhigh_in, op_code=ir[31:27]. Next T5.
- T5:
  - mul/div: zlow_out, lo_in; next T6.
  - otherwise: zlow_out, reg_in[Ra]; next END.
- T6: zhigh_out, hi_in. Next END.
- END is not a state: the transition goes to T0 if run=1, else IDLE. run is sampled only at END and in IDLE; dropping run mid-instruction completes the instruction.
- HALT: halted=1, all strobes 0. Exits only via clr.
- Latency:
  - simple ALU op: 6 cycles T0..T5.
  - mul/div: 7 cycles.
  - nop/illegal/halt: 4 cycles.
  - back-to-back instructions have zero dead cycles.
- Ra, Rb and Rc may be equal, since each is used in a separate cycle. R0 is writable like any other register.
- Opcode map:
  - ALU class: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, mul 01111, div 10000.
  - Other: nop 11010, halt 11011.
  - All remaining opcodes are undefined.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams;
  - state enum (IDLE, T0–T6, HALT);
  - IR field bit positions;
  - function is_alu_op(opcode);
  - function is_hilo_op(opcode).
- One sub-module, reg_field_decoder: converts a 4-bit register field plus an enable into an NREGS one-hot vector. It is instantiated twice, for reg_in and reg_out.

Test Plan:
- Reset: clr=1 for 3 cycles with run=1 → all outputs 0, halted=0. Release clr → T0 strobes on the first following cycle.
- shl: ir=32'h5A3B8000 (opcode 01011, Ra=4, Rb=7, Rc=7), run=1 → strobes follow T0..T5 in order:
  - T3: reg_out=16'h0080, y_in.
  - T4: reg_out=16'h0080, op_code=01011, zlow_in.
  - T5: reg_in=16'h0010, zlow_out.
  - Next cycle is T0.
- mul: ir opcode 01111 → T5 drives zlow_out and lo_in with reg_in=0. T6 drives zhigh_out and hi_in. Total 7 cycles.
- halt and illegal:
  - opcode 11011 at T3 → halted=1 from the next cycle; all strobes stay 0 for 20 cycles.
  - opcode 11111 → illegal high for exactly one cycle (T3), then T0.
- run timing: run deasserted during T4 of an add → T5 completes normally, then IDLE with all outputs 0. Reasserting run → T0 on the next cycle.
- Async reset mid-execute: clr pulsed between clock edges during T4 → all outputs drop to 0 before the next edge. Restart begins at T0.
